// File: rtl/mdec_pkg.sv
// rtl/mdec_pkg.sv - shared constants and decode state type for the MDEC RLE front end
package mdec_pkg;

   localparam logic [15:0] EOB_CODE  = 16'hFE00;
   localparam int          QSCALE_W  = 6;
   localparam int          COEF_W    = 10;
   localparam int          IDX_W     = 6;
   localparam int          MAX_INDEX = 63;

   typedef enum logic {
      ST_DC = 1'b0,
      ST_AC = 1'b1
   } rle_state_e;

endpackage

// File: rtl/rle_fetch_if.sv
// rtl/rle_fetch_if.sv - FIFO read side and decoded coefficient beat stream of rle_fetch
interface rle_fetch_if #(
   parameter int COEF_W = mdec_pkg::COEF_W,
   parameter int IDX_W  = mdec_pkg::IDX_W
);

   logic                          fifo_empty_i;
   logic                          fifo_rd_en_o;
   logic [15:0]                   fifo_data_i;
   logic                          out_valid_o;
   logic                          out_ready_i;
   logic                          out_dc_o;
   logic                          out_eob_o;
   logic [mdec_pkg::QSCALE_W-1:0] out_qscale_o;
   logic [IDX_W-1:0]              out_index_o;
   logic [COEF_W-1:0]             out_coef_o;
   logic                          err_overflow_o;

   modport master (
      input  fifo_empty_i, fifo_data_i, out_ready_i,
      output fifo_rd_en_o, out_valid_o, out_dc_o, out_eob_o,
             out_qscale_o, out_index_o, out_coef_o, err_overflow_o
   );

   modport slave (
      output fifo_empty_i, fifo_data_i, out_ready_i,
      input  fifo_rd_en_o, out_valid_o, out_dc_o, out_eob_o,
             out_qscale_o, out_index_o, out_coef_o, err_overflow_o
   );

endinterface

// File: rtl/rle_skid2.sv
// rtl/rle_skid2.sv - two-entry holding buffer, valid/ready on both sides, head entry drives the output
module rle_skid2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] s_tdata,
   input  logic         s_tvalid,
   output logic         s_tready,
   output logic [W-1:0] m_tdata,
   output logic         m_tvalid,
   input  logic         m_tready,
   output logic [1:0]   count
);

   logic [W-1:0] mem0, mem1;
   logic [1:0]   cnt_q;
   logic         push, pop;

   assign m_tvalid = (cnt_q != 2'd0);
   assign m_tdata  = mem0;
   assign pop      = m_tvalid & m_tready;
   assign s_tready = (cnt_q != 2'd2) | pop;
   assign push     = s_tvalid & s_tready;
   assign count    = cnt_q;

   // mem0 only changes on a pop or a push into an empty buffer, so a stalled head stays put
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem0  <= '0;
         mem1  <= '0;
         cnt_q <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt_q == 2'd0) mem0 <= s_tdata;
               else               mem1 <= s_tdata;
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               mem0  <= mem1;
               cnt_q <= cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  mem0 <= s_tdata;
               end else begin
                  mem0 <= mem1;
                  mem1 <= s_tdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/rle_fetch.sv
// rtl/rle_fetch.sv - run/level word fetch and decode into DC/AC/EOB coefficient beats
// Optional RLE_BLOCK_COUNT_EN adds block_count_o, counting accepted EOB beats.
module rle_fetch
   import mdec_pkg::EOB_CODE, mdec_pkg::QSCALE_W, mdec_pkg::MAX_INDEX,
          mdec_pkg::rle_state_e, mdec_pkg::ST_DC, mdec_pkg::ST_AC;
#(
   parameter int COEF_W = mdec_pkg::COEF_W,
   parameter int IDX_W  = mdec_pkg::IDX_W
) (
   input  logic         clk,
   input  logic         rst,
   rle_fetch_if.master  bus
`ifdef RLE_BLOCK_COUNT_EN
   ,
   output logic [15:0]  block_count_o
`endif
);

   localparam int BEAT_W = 2 + QSCALE_W + IDX_W + COEF_W;

   rle_state_e           state_q, state_d;
   logic [IDX_W-1:0]     index_q, index_d;
   logic [QSCALE_W-1:0]  qscale_q, qscale_d;
   logic                 overflow_q, overflow_d;
   logic                 inflight_q;
   logic [15:0]          word;
   logic [IDX_W:0]       idx_sum;

   logic                 b_dc, b_eob;
   logic [IDX_W-1:0]     b_index;
   logic [COEF_W-1:0]    b_coef;
   logic                 push_valid, push_ready;
   logic [BEAT_W-1:0]    push_data, head_data;
   logic                 head_valid, pop;
   logic [1:0]           buf_count;

   assign word = bus.fifo_data_i;
   assign pop  = head_valid & bus.out_ready_i;

   // A read is a credit on buffer space: the word lands two edges later, and a pop this cycle frees a slot
   assign bus.fifo_rd_en_o = !rst && !bus.fifo_empty_i &&
      (({1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) inflight_q <= 1'b0;
      else     inflight_q <= bus.fifo_rd_en_o;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_DC;
         index_q    <= '0;
         qscale_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         qscale_q   <= qscale_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      qscale_d   = qscale_q;
      overflow_d = overflow_q;
      push_valid = 1'b0;
      b_dc       = 1'b0;
      b_eob      = 1'b0;
      b_index    = index_q;
      b_coef     = '0;
      idx_sum    = {1'b0, index_q} + (IDX_W+1)'(word[15:10]) + (IDX_W+1)'(1);
      if (inflight_q) begin
         case (state_q)
            ST_DC: begin
               if (word != EOB_CODE) begin
                  qscale_d   = word[15:10];
                  index_d    = '0;
                  push_valid = 1'b1;
                  b_dc       = 1'b1;
                  b_index    = '0;
                  b_coef     = COEF_W'(signed'(word[9:0]));
                  state_d    = ST_AC;
               end
            end
            ST_AC: begin
               if (word == EOB_CODE) begin
                  push_valid = 1'b1;
                  b_eob      = 1'b1;
                  state_d    = ST_DC;
               end else if (idx_sum > (IDX_W+1)'(MAX_INDEX)) begin
                  // Run walked off the block: close it at the last position and drop the level
                  overflow_d = 1'b1;
                  push_valid = 1'b1;
                  b_eob      = 1'b1;
                  b_index    = IDX_W'(MAX_INDEX);
                  state_d    = ST_DC;
               end else begin
                  push_valid = 1'b1;
                  b_index    = idx_sum[IDX_W-1:0];
                  b_coef     = COEF_W'(signed'(word[9:0]));
                  index_d    = idx_sum[IDX_W-1:0];
               end
            end
            default: state_d = ST_DC;
         endcase
      end
      push_data = {b_dc, b_eob, qscale_d, b_index, b_coef};
   end

   rle_skid2 #(.W(BEAT_W)) u_hold (
      .clk      (clk),
      .rst      (rst),
      .s_tdata  (push_data),
      .s_tvalid (push_valid),
      .s_tready (push_ready),
      .m_tdata  (head_data),
      .m_tvalid (head_valid),
      .m_tready (bus.out_ready_i),
      .count    (buf_count)
   );

   a_no_push_drop: assert property (@(posedge clk) disable iff (rst) push_valid |-> push_ready);

   assign bus.out_valid_o    = head_valid;
   assign {bus.out_dc_o, bus.out_eob_o, bus.out_qscale_o, bus.out_index_o, bus.out_coef_o} = head_data;
   assign bus.err_overflow_o = overflow_q;

`ifdef RLE_BLOCK_COUNT_EN
   logic [15:0] block_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                block_cnt_q <= 16'd0;
      else if (pop && head_data[BEAT_W-2])    block_cnt_q <= block_cnt_q + 16'd1;
   end

   assign block_count_o = block_cnt_q;
`endif

endmodule

// File: tb/tb_rle_fetch.sv
// tb/tb_rle_fetch.sv - directed table-driven bench for rle_fetch with a FIFO model and beat monitor
module tb_rle_fetch;

   typedef struct {
      logic [15:0] word;
      bit          emits;
      logic        dc;
      logic        eob;
      logic [5:0]  q;
      logic [5:0]  idx;
      logic [9:0]  coef;
   } vec_t;

   typedef struct {
      logic       dc;
      logic       eob;
      logic [5:0] q;
      logic [5:0] idx;
      logic [9:0] coef;
      int         cyc;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rle_fetch_if #(.COEF_W(10), .IDX_W(6)) bus ();

`ifdef RLE_BLOCK_COUNT_EN
   logic [15:0] block_count;
`endif

   rle_fetch #(.COEF_W(10), .IDX_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef RLE_BLOCK_COUNT_EN
      ,
      .block_count_o (block_count)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // FIFO model: data appears the edge after a pop strobe; cleared by the same rst
   logic [15:0] fmem [0:255];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   assign bus.fifo_empty_i = (rd_ptr == wr_ptr);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= wr_ptr;
      end else if (bus.fifo_rd_en_o) begin
         bus.fifo_data_i <= fmem[rd_ptr];
         rd_ptr          <= rd_ptr + 1;
      end
   end

   task automatic push_word(input logic [15:0] w);
      fmem[wr_ptr] = w;
      wr_ptr++;
   endtask

   int   ready_mode = 0;
   logic rdy = 1'b1;
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       rdy = 1'b1;
         1:       rdy = ~rdy;
         default: rdy = 1'b0;
      endcase
      bus.out_ready_i = rdy;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   beat_t       cap[$];
   int          rd_log[$];
   bit          prev_stall = 0;
   logic [24:0] prev_fields;
   logic [24:0] cur_fields;
   int          stall_checks = 0;
   int          stall_bad = 0;

   always @(negedge clk) begin
      cur_fields = {bus.out_valid_o, bus.out_dc_o, bus.out_eob_o, bus.out_qscale_o,
                    bus.out_index_o, bus.out_coef_o};
      if (rst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            stall_checks++;
            if (cur_fields !== prev_fields) begin
               stall_bad++;
               $display("FAIL stall_stable actual=%h required=%h", cur_fields, prev_fields);
            end
         end
         if (bus.fifo_rd_en_o) rd_log.push_back(cyc);
         if (bus.out_valid_o && bus.out_ready_i)
            cap.push_back('{bus.out_dc_o, bus.out_eob_o, bus.out_qscale_o,
                            bus.out_index_o, bus.out_coef_o, cyc});
         prev_stall  = bus.out_valid_o && !bus.out_ready_i;
         prev_fields = cur_fields;
      end
   end

   function automatic vec_t v(input logic [15:0] w, input bit e, input logic dc, input logic eob,
                              input logic [5:0] q, input logic [5:0] idx, input logic [9:0] c);
      vec_t r;
      r.word = w; r.emits = e; r.dc = dc; r.eob = eob; r.q = q; r.idx = idx; r.coef = c;
      return r;
   endfunction

   function automatic logic [23:0] pk(input beat_t b);
      return {b.dc, b.eob, b.q, b.idx, b.coef};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   vec_t tbl[$];

   task automatic run_table(input string tag, input int mode);
      int base;
      int n;
      int k;
      n    = 0;
      base = cap.size();
      ready_mode = mode;
      foreach (tbl[i]) begin
         push_word(tbl[i].word);
         if (tbl[i].emits) n++;
      end
      for (int t = 0; t < 300 && cap.size() < base + n; t++) tick();
      repeat (6) tick();
      check({tag, "_count"}, cap.size() - base, n);
      k = base;
      foreach (tbl[i]) begin
         if (tbl[i].emits) begin
            if (k < cap.size())
               check($sformatf("%s_beat%0d", tag, k - base), pk(cap[k]),
                     {tbl[i].dc, tbl[i].eob, tbl[i].q, tbl[i].idx, tbl[i].coef});
            k++;
         end
      end
      tbl.delete();
      ready_mode = 0;
   endtask

   initial begin
      int lat_rd, lat_cap, b_rd, b_cap;
      int span;

      repeat (2) @(posedge clk);
      #2;
      check("rst_rd_en",  bus.fifo_rd_en_o,   0);
      check("rst_valid",  bus.out_valid_o,    0);
      check("rst_dc",     bus.out_dc_o,       0);
      check("rst_eob",    bus.out_eob_o,      0);
      check("rst_qscale", bus.out_qscale_o,   0);
      check("rst_index",  bus.out_index_o,    0);
      check("rst_coef",   bus.out_coef_o,     0);
      check("rst_err",    bus.err_overflow_o, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) tick();

      // Single block from idle: two-cycle pop-to-beat latency
      lat_rd  = rd_log.size();
      lat_cap = cap.size();
      tbl.push_back(v(16'h2C05, 1, 1, 0, 6'd11, 6'd0, 10'd5));
      tbl.push_back(v(16'hFE00, 1, 0, 1, 6'd11, 6'd0, 10'd0));
      run_table("lat", 0);
      if (cap.size() > lat_cap && rd_log.size() > lat_rd)
         check("latency", cap[lat_cap].cyc - rd_log[lat_rd], 2);

      // Padding, DC, AC, EOB with continuous ready, then with ready toggling
      for (int pass = 0; pass < 2; pass++) begin
         tbl.push_back(v(16'hFE00, 0, 0, 0, 6'd0,  6'd0, 10'd0));
         tbl.push_back(v(16'hFE00, 0, 0, 0, 6'd0,  6'd0, 10'd0));
         tbl.push_back(v(16'h2C05, 1, 1, 0, 6'd11, 6'd0, 10'd5));
         tbl.push_back(v(16'h0403, 1, 0, 0, 6'd11, 6'd2, 10'd3));
         tbl.push_back(v(16'hFE00, 1, 0, 1, 6'd11, 6'd2, 10'd0));
         run_table(pass == 0 ? "basic" : "toggle", pass);
      end
      check("stall_stable", stall_bad, 0);
      check("stall_seen", stall_checks > 0, 1);

      // Run landing exactly on index 63 is legal
      tbl.push_back(v(16'h0400, 1, 1, 0, 6'd1, 6'd0,  10'd0));
      tbl.push_back(v(16'hF801, 1, 0, 0, 6'd1, 6'd63, 10'd1));
      tbl.push_back(v(16'hFE00, 1, 0, 1, 6'd1, 6'd63, 10'd0));
      run_table("edge63", 0);
      check("err_after_edge63", bus.err_overflow_o, 0);

      // Run to 64 overflows; flag stays set through the following negative-level block
      tbl.push_back(v(16'h0801, 1, 1, 0, 6'd2, 6'd0,  10'd1));
      tbl.push_back(v(16'hFC01, 1, 0, 1, 6'd2, 6'd63, 10'd0));
      tbl.push_back(v(16'h0805, 1, 1, 0, 6'd2, 6'd0,  10'd5));
      tbl.push_back(v(16'h0BFF, 1, 0, 0, 6'd2, 6'd3,  10'h3FF));
      tbl.push_back(v(16'hFE00, 1, 0, 1, 6'd2, 6'd3,  10'd0));
      run_table("ovf", 0);
      check("err_sticky", bus.err_overflow_o, 1);

      // 64 back-to-back words with the FIFO never running dry
      b_rd  = rd_log.size();
      b_cap = cap.size();
      push_word(16'h0405);
      for (int k = 1; k < 64; k++) push_word({6'd0, 10'(k)});
      for (int t = 0; t < 300 && cap.size() < b_cap + 64; t++) tick();
      repeat (4) tick();
      check("b2b_beats", cap.size() - b_cap, 64);
      check("b2b_reads", rd_log.size() - b_rd, 64);
      if (cap.size() >= b_cap + 64 && rd_log.size() >= b_rd + 64) begin
         check("b2b_rd_contiguous", rd_log[b_rd + 63] - rd_log[b_rd], 63);
         span = cap[b_cap + 63].cyc - rd_log[b_rd] + 1;
         check("b2b_cycles_in_range", (span >= 65) && (span <= 66), 1);
         check("b2b_dc", pk(cap[b_cap]), {1'b1, 1'b0, 6'd1, 6'd0, 10'd5});
         for (int k = 1; k < 64; k++)
            check($sformatf("b2b_ac%0d", k), pk(cap[b_cap + k]),
                  {1'b0, 1'b0, 6'd1, 6'(k), 10'(k)});
      end
      tbl.push_back(v(16'hFE00, 1, 0, 1, 6'd1, 6'd63, 10'd0));
      run_table("b2b_eob", 0);

      // Asynchronous reset mid-block with words still in flight
      b_cap = cap.size();
      push_word(16'h0805);
      push_word(16'h0403);
      push_word(16'h0402);
      push_word(16'h0401);
      for (int t = 0; t < 50 && cap.size() < b_cap + 2; t++) tick();
      check("pre_rst_beats", cap.size() - b_cap, 2);
      #1;
      rst = 1'b1;
      #1;
      check("arst_rd_en",  bus.fifo_rd_en_o,   0);
      check("arst_valid",  bus.out_valid_o,    0);
      check("arst_fields", {bus.out_dc_o, bus.out_eob_o, bus.out_qscale_o,
                            bus.out_index_o, bus.out_coef_o}, 0);
      check("arst_err",    bus.err_overflow_o, 0);
      repeat (2) tick();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) tick();
      tbl.push_back(v(16'h2C05, 1, 1, 0, 6'd11, 6'd0, 10'd5));
      tbl.push_back(v(16'hFE00, 1, 0, 1, 6'd11, 6'd0, 10'd0));
      run_table("post_rst", 0);
      check("post_rst_err", bus.err_overflow_o, 0);

`ifdef RLE_BLOCK_COUNT_EN
      check("blkcnt_after_one", block_count, 1);
      for (int b = 0; b < 2; b++) begin
         tbl.push_back(v(16'h0400, 1, 1, 0, 6'd1, 6'd0, 10'd0));
         tbl.push_back(v(16'hFE00, 1, 0, 1, 6'd1, 6'd0, 10'd0));
      end
      run_table("blkcnt", 0);
      check("blkcnt_three", block_count, 3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule

// File: doc/rle_fetch.md
RLE_FETCH -- requirements
Module: rle_fetch

Interface
REQ-001 Parameter COEF_W, default 10: signed coefficient width.
REQ-002 Parameter IDX_W, default 6: zigzag index width (64 positions).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fifo_empty_i  input  1  upstream halfword FIFO empty flag.
REQ-006 fifo_rd_en_o  output  1  FIFO pop strobe.
REQ-007 fifo_data_i  input  16  FIFO read data, valid the cycle after fifo_rd_en_o.
REQ-008 out_valid_o  output  1  output beat valid.
REQ-009 out_ready_i  input  1  downstream accepts beat.
REQ-010 out_dc_o  output  1  beat is the block's DC term.
REQ-011 out_eob_o  output  1  beat is the end-of-block marker.
REQ-012 out_qscale_o  output  6  quant scale latched from DC word.
REQ-013 out_index_o  output  IDX_W  zigzag index of coefficient.
REQ-014 out_coef_o  output  COEF_W  signed coefficient.
REQ-015 err_overflow_o  output  1  sticky: run pushed index past 63.

Function
REQ-016 A beat transfers when out_valid_o and out_ready_i are both high in one cycle; out_* fields shall hold stable while out_valid_o is high and out_ready_i is low.
REQ-017 Decoded words shall go into a 2-entry holding buffer; fifo_rd_en_o shall assert only when !fifo_empty_i and (buffered + in-flight words) < 2, giving one word per cycle under continuous ready.
REQ-018 A word shall be captured exactly one cycle after its fifo_rd_en_o; no word lost or duplicated under any out_ready_i pattern.
REQ-019 FSM states: DC (expect block header) and AC (expect run/level); reset state DC.
REQ-020 DC, word==16'hFE00: discard as padding, emit nothing, stay DC.
REQ-021 DC, other word: qscale=word[15:10], coef=sign-extended word[9:0], index=0, out_dc_o=1; enter AC.
REQ-022 AC, word==16'hFE00: emit beat with out_eob_o=1, coef=0, index=current; enter DC.
REQ-023 AC, other word: index += word[15:10]+1 computed IDX_W+1 wide; if <=63 emit coef word[9:0] at new index, stay AC.
REQ-024 AC, computed index >63: set err_overflow_o, emit EOB beat at index 63, discard word, enter DC.
REQ-025 Latency: beat available on out_* two cycles after fifo_rd_en_o when buffer empty and ready high.
REQ-026 err_overflow_o clears only on rst.
REQ-027 out_qscale_o shall persist unchanged across AC and EOB beats until the next DC word.

Reset
REQ-028 On rst: fifo_rd_en_o=0, out_valid_o=0, out_dc_o=0, out_eob_o=0, out_qscale_o=0, out_index_o=0, out_coef_o=0, err_overflow_o=0, buffer and in-flight count cleared, FSM=DC.
REQ-029 rst mid-block discards any in-flight FIFO word; upstream FIFO is reset by the same rst.

Configuration
REQ-030 Macro RLE_BLOCK_COUNT_EN defined: extra output block_count_o [15:0], reset 0, increments on each accepted EOB beat, wraps 16'hFFFF->0.
REQ-031 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-032 Shared package mdec_pkg holds EOB_CODE=16'hFE00, QSCALE_W=6, COEF_W, IDX_W, MAX_INDEX=63 and the DC/AC state enum.
REQ-033 Holding buffer shall be a sub-module rle_skid2 (2-entry, valid/ready both sides); FSM and decode stay in rle_fetch.

Verification
REQ-034 FIFO holds FE00,FE00,2C05,0403,FE00; ready=1 -> beats: DC q=11 coef=5 idx0; AC coef=3 idx2; EOB idx2; padding emits nothing.
REQ-035 Same stream, out_ready_i toggling 1/0 each cycle -> identical beat sequence, no drop/duplicate, fields stable while stalled.
REQ-036 DC 0801 then AC FC01 (run 63) -> EOB idx63, err_overflow_o=1 and stays 1 through next valid block.
REQ-037 64 back-to-back words, fifo never empty, ready=1 -> fifo_rd_en_o high every cycle after first; 64 beats in 65-66 cycles.
REQ-038 rst asserted asynchronously mid-AC with word in flight -> all outputs 0 immediately; next DC word decodes as fresh block.
REQ-039 With RLE_BLOCK_COUNT_EN, 3 complete blocks -> block_count_o=3; preset 16'hFFFF plus one block -> 0.
